// File: rtl/block_ram_responder_pkg.sv
// Shared types and default parameters for the block RAM responder and its harnesses.
package block_ram_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_READ_PRIME = 3'd2,
    ST_READ       = 3'd3,
    ST_REFRESH    = 3'd4
  } state_e;

  localparam int unsigned DATA_W                   = 16;
  localparam int unsigned DEF_BLOCK_WIDTH          = 21;
  localparam int unsigned DEF_BLOCK_SIZE           = 16;
  localparam int unsigned DEF_BLOCK_COUNT          = 16;
  localparam int unsigned DEF_REFRESH_INTERVAL     = 64;
  localparam int unsigned DEF_REFRESH_CYCLES       = 4;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/block_ram_responder_ram.sv
// Single-port 16-bit block RAM: synchronous write, synchronous registered read.
module block_ram_responder_ram
  import block_ram_responder_pkg::*;
#(
  parameter int unsigned AddrW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [AddrW-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DATA_W-1:0] mem [Depth];

  // Array is deliberately left without reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/block_ram_responder.sv
// Block-oriented read/write responder in front of a single-port RAM with periodic refresh stalls.
module block_ram_responder
  import block_ram_responder_pkg::*;
#(
  parameter int unsigned BlockWidth      = DEF_BLOCK_WIDTH,
  parameter int unsigned BlockSize       = DEF_BLOCK_SIZE,
  parameter int unsigned BlockCount      = DEF_BLOCK_COUNT,
  parameter int unsigned RefreshInterval = DEF_REFRESH_INTERVAL,
  parameter int unsigned RefreshCycles   = DEF_REFRESH_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  cmd_ready,
  input  logic                  cmd_trigger,
  input  logic [BlockWidth-1:0] cmd_block,
  input  logic                  cmd_write,
  output logic                  data_ready,
  input  logic                  data_trigger,
  input  logic [DATA_W-1:0]     data_write,
  output logic [DATA_W-1:0]     data_read
);

  localparam int unsigned BlkW  = cnt_width(BlockCount);
  localparam int unsigned IdxW  = cnt_width(BlockSize);
  localparam int unsigned AddrW = BlkW + IdxW;
  localparam int unsigned CntW  = cnt_width(RefreshInterval);
  localparam int unsigned RfW   = cnt_width(RefreshCycles);

  state_e            state;
  state_e            resume_state;
  logic [BlkW-1:0]   blk;
  logic [IdxW-1:0]   word_idx;
  logic [CntW-1:0]   rcnt;
  logic [RfW-1:0]    rf_cnt;

  state_e            hs_state_c;
  state_e            next_state_c;
  logic              cmd_acc_c;
  logic              xfer_c;
  logic              last_c;
  logic              refresh_start_c;
  logic              refresh_end_c;
  logic              ram_en_c;
  logic              ram_we_c;
  logic [AddrW-1:0]  ram_addr_c;
  logic              unused_c;

  assign unused_c = ^cmd_block[BlockWidth-1:BlkW];

  // Handshake decode, post-handshake state and RAM port control.
  always_comb begin
    cmd_acc_c       = (state == ST_IDLE) && cmd_trigger;
    xfer_c          = ((state == ST_WRITE) || (state == ST_READ)) && data_trigger;
    last_c          = xfer_c && (word_idx == IdxW'(BlockSize - 1));
    refresh_start_c = (rcnt == CntW'(RefreshInterval - 1));
    refresh_end_c   = (state == ST_REFRESH) && (rf_cnt == RfW'(RefreshCycles - 1));
    hs_state_c      = state;
    ram_en_c        = 1'b0;
    ram_we_c        = 1'b0;
    ram_addr_c      = {blk, word_idx};

    case (state)
      ST_IDLE: begin
        if (cmd_acc_c) begin
          hs_state_c = cmd_write ? ST_WRITE : ST_READ_PRIME;
        end
      end
      ST_WRITE: begin
        ram_en_c = xfer_c;
        ram_we_c = xfer_c;
        if (last_c) begin
          hs_state_c = ST_IDLE;
        end
      end
      ST_READ_PRIME: begin
        ram_en_c   = 1'b1;
        ram_addr_c = {blk, IdxW'(0)};
        hs_state_c = ST_READ;
      end
      ST_READ: begin
        // Prefetch the following word so it is on data_read the cycle after a transfer.
        ram_en_c   = xfer_c;
        ram_addr_c = {blk, word_idx + IdxW'(1)};
        if (last_c) begin
          hs_state_c = ST_IDLE;
        end
      end
      default: hs_state_c = state;
    endcase

    if (refresh_start_c) begin
      next_state_c = ST_REFRESH;
    end else if (refresh_end_c) begin
      next_state_c = resume_state;
    end else begin
      next_state_c = hs_state_c;
    end
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      resume_state <= ST_IDLE;
      blk          <= '0;
      word_idx     <= '0;
      rcnt         <= '0;
      rf_cnt       <= '0;
      cmd_ready    <= 1'b1;
      data_ready   <= 1'b0;
    end else begin
      state      <= next_state_c;
      cmd_ready  <= (next_state_c == ST_IDLE);
      data_ready <= (next_state_c == ST_WRITE) || (next_state_c == ST_READ);
      rcnt       <= refresh_start_c ? '0 : rcnt + CntW'(1);

      if (refresh_start_c) begin
        resume_state <= hs_state_c;
      end

      if ((state == ST_REFRESH) && !refresh_end_c) begin
        rf_cnt <= rf_cnt + RfW'(1);
      end else begin
        rf_cnt <= '0;
      end

      if (cmd_acc_c) begin
        blk      <= cmd_block[BlkW-1:0];
        word_idx <= '0;
      end else if (xfer_c) begin
        word_idx <= word_idx + IdxW'(1);
      end
    end
  end

  block_ram_responder_ram #(
    .AddrW(AddrW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en_c),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (data_write),
    .rdata (data_read)
  );

endmodule

// File: tb/tb_block_ram_responder.sv
// Bench for block_ram_responder: transaction-level reference model plus directed and random traffic.
module tb_block_ram_responder;

  localparam int RI = 32;
  localparam int RC = 4;
  localparam int BS = 16;
  localparam int BC = 16;

  logic        clk;
  logic        rst;
  logic        cmd_ready;
  logic        cmd_trigger;
  logic [20:0] cmd_block;
  logic        cmd_write;
  logic        data_ready;
  logic        data_trigger;
  logic [15:0] data_write;
  logic [15:0] data_read;

  block_ram_responder #(
    .BlockWidth(21), .BlockSize(BS), .BlockCount(BC),
    .RefreshInterval(RI), .RefreshCycles(RC)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_ready(cmd_ready), .cmd_trigger(cmd_trigger), .cmd_block(cmd_block), .cmd_write(cmd_write),
    .data_ready(data_ready), .data_trigger(data_trigger), .data_write(data_write), .data_read(data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase of the transaction, cycle index since reset, memory image.
  localparam int PH_IDLE = 0, PH_WR = 1, PH_PRIME = 2, PH_RD = 3;
  int          k = 0;
  int          phase = PH_IDLE;
  int          m_blk = 0;
  int          m_idx = 0;
  logic [15:0] mem [BS*BC];
  bit          valid [BS*BC];

  initial for (int i = 0; i < BS*BC; i++) valid[i] = 1'b0;

  always @(negedge clk) begin
    bit stall;
    int a;
    if (rst) begin
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_data_ready", 32'(data_ready), 32'd0);
      chk("rst_data_read", 32'(data_read), 32'd0);
      k = 0; phase = PH_IDLE; m_idx = 0;
    end else begin
      stall = (k >= RI) && ((k % RI) < RC);
      a = m_blk * BS + m_idx;
      chk("cmd_ready", 32'(cmd_ready), 32'(!stall && phase == PH_IDLE));
      chk("data_ready", 32'(data_ready), 32'(!stall && (phase == PH_WR || phase == PH_RD)));
      if (phase == PH_RD && valid[a]) chk("data_read", 32'(data_read), 32'(mem[a]));
      if (!stall) begin
        case (phase)
          PH_IDLE: if (cmd_trigger) begin
            m_blk = int'(cmd_block[3:0]); m_idx = 0;
            phase = cmd_write ? PH_WR : PH_PRIME;
          end
          PH_WR: if (data_trigger) begin
            mem[a] = data_write; valid[a] = 1'b1; m_idx++;
            if (m_idx == BS) begin phase = PH_IDLE; m_idx = 0; end
          end
          PH_PRIME: phase = PH_RD;
          default: if (data_trigger) begin
            m_idx++;
            if (m_idx == BS) begin phase = PH_IDLE; m_idx = 0; end
          end
        endcase
      end
      k++;
    end
  end

  logic [15:0] rq [$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sync_to(input int ph);
    int g = 0;
    do begin tick(); g++; end while (!((k >= RI) && ((k % RI) == ph)) && g < 200);
    chk("sync_in_time", 32'(g < 200), 32'd1);
  endtask

  task automatic do_cmd(input logic wr, input logic [20:0] b);
    bit ok = 1'b0;
    cmd_trigger = 1'b1; cmd_write = wr; cmd_block = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); ok = cmd_ready;
      tick();
    end
    cmd_trigger = 1'b0;
    chk("cmd_accepted", 32'(ok), 32'd1);
  endtask

  task automatic do_write(input int n, input logic [15:0] base);
    int i = 0;
    int g = 0;
    data_trigger = 1'b1; data_write = base;
    while (i < n && g < 400) begin
      @(negedge clk); if (data_ready) i++;
      tick(); data_write = base + 16'(i); g++;
    end
    data_trigger = 1'b0;
    chk("write_done", 32'(i), 32'(n));
  endtask

  task automatic do_read(input int n, input bit toggle);
    int i = 0;
    int g = 0;
    rq.delete();
    data_trigger = 1'b1;
    while (i < n && g < 400) begin
      @(negedge clk);
      if (data_ready && data_trigger) begin rq.push_back(data_read); i++; end
      tick(); g++;
      if (toggle) data_trigger = !data_trigger;
    end
    data_trigger = 1'b0;
    chk("read_done", 32'(i), 32'(n));
  endtask

  task automatic check_seq(input string name, input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++)
      chk(name, (i < rq.size()) ? 32'(rq[i]) : 32'hDEAD_BEEF, 32'(base + 16'(i)));
  endtask

  initial begin
    int lows;
    rst = 1'b1; cmd_trigger = 1'b0; cmd_block = '0; cmd_write = 1'b0;
    data_trigger = 1'b0; data_write = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Idle refresh pattern: 4 stall cycles in every 32.
    sync_to(0);
    lows = 0;
    for (int c = 0; c < 3*RI; c++) begin
      @(negedge clk); if (!cmd_ready) lows++;
      tick();
    end
    chk("refresh_low_count", 32'(lows), 32'd12);

    // Write block 3; read command raised during the final write transfer.
    sync_to(4);
    do_cmd(1'b1, 21'd3);
    do_write(15, 16'h1000);
    data_trigger = 1'b1; data_write = 16'h100F;
    cmd_trigger = 1'b1; cmd_write = 1'b0; cmd_block = 21'd3;
    @(negedge clk);
    chk("last_xfer_data_ready", 32'(data_ready), 32'd1);
    chk("last_xfer_cmd_ready", 32'(cmd_ready), 32'd0);
    tick(); data_trigger = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_last", 32'(cmd_ready), 32'd1);
    tick(); cmd_trigger = 1'b0;
    @(negedge clk);
    chk("prime_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("prime_data_ready", 32'(data_ready), 32'd0);
    tick();
    do_read(16, 1'b0);
    check_seq("read_blk3", 16'h1000, 16);

    // Read with toggling data_trigger.
    do_cmd(1'b0, 21'd3);
    do_read(16, 1'b1);
    check_seq("toggle_read_blk3", 16'h1000, 16);

    // Upper block bits are ignored.
    do_cmd(1'b1, 21'h13);
    do_write(16, 16'h2000);
    do_cmd(1'b0, 21'd3);
    do_read(16, 1'b0);
    check_seq("alias_blk3", 16'h2000, 16);

    // Reset in the middle of a write keeps the words already stored.
    do_cmd(1'b1, 21'd5);
    do_write(5, 16'h5000);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_data_ready", 32'(data_ready), 32'd0);
    tick(); rst = 1'b0;
    do_cmd(1'b0, 21'd5);
    do_read(16, 1'b0);
    check_seq("partial_blk5", 16'h5000, 5);

    // Random traffic against the model, with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      cmd_trigger  = ($urandom_range(0, 3) == 0);
      cmd_write    = 1'($urandom_range(0, 1));
      cmd_block    = 21'($urandom);
      data_trigger = ($urandom_range(0, 2) != 0);
      data_write   = 16'($urandom);
      rst          = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; cmd_trigger = 1'b0; data_trigger = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
